uart_tx_fifo: RTL and testbench

Transmit-side buffer and launcher placed directly upstream of `uart_tx`. Accepts bytes from a host-side write port into a synchronous FIFO. Hands them one at a time to `uart_tx` by pulsing its start input with a stable data byte, then waits for `o_tx_done` before launching the next byte. Decouples bursty host writes from the serial line rate.

---
 rtl/uart_tx_fifo_pkg.sv | 18 +
 rtl/uart_tx_fifo_sync_fifo.sv | 90 +++++++++
 rtl/uart_tx_fifo.sv | 120 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: shared helpers for the UART transmit buffer slice.
// Contents:
//   ptr_inc - circular-buffer pointer increment that wraps from depth-1 to 0.
package uart_tx_fifo_pkg;

  // Next position of a circular-buffer pointer. The wrap is written out
  // explicitly, so it does not depend on the pointer width matching the depth.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    logic [31:0] v_next;
    if (ptr == depth - 32'd1) begin
      v_next = 32'd0;
    end else begin
      v_next = ptr + 32'd1;
    end
    return v_next;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: synchronous circular-buffer FIFO with registered status.
// Ports:
//   clk, reset             - rising-edge clock, synchronous active-high reset
//   i_wr, i_wr_data        - write strobe and data. Ignored while full.
//   i_rd                   - pop strobe. Ignored while empty.
//   o_rd_data              - head entry. Valid while o_empty is 0.
//   o_full, o_empty        - registered status decoded from the next count
//   o_count                - registered occupancy, 0..DEPTH
//   o_wr_err               - one-cycle pulse after a write was dropped while full
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd,
  output logic [WIDTH-1:0]  o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_wr_err
);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   w_count_nxt;
  logic              r_full;
  logic              r_empty;
  logic              r_wr_err;
  logic              w_wr_ok;
  logic              w_rd_ok;

  // Full is judged on the registered flag, so a same-cycle pop never frees room.
  assign w_wr_ok = i_wr & ~r_full;
  assign w_rd_ok = i_rd & ~r_empty;

  // Occupancy after this edge. A simultaneous write and pop leaves it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + (ADDR_W+1)'(1);
      2'b01:   w_count_nxt = r_count - (ADDR_W+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, count, status flags and the overflow pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_wr_err <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= ADDR_W'(ptr_inc(32'(r_wr_ptr), 32'(DEPTH)));
      end
      if (w_rd_ok) begin
        r_rd_ptr <= ADDR_W'(ptr_inc(32'(r_rd_ptr), 32'(DEPTH)));
      end
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == (ADDR_W+1)'(DEPTH));
      r_empty  <= (w_count_nxt == (ADDR_W+1)'(0));
      r_wr_err <= i_wr & r_full;
    end
  end

  // Storage. It is not reset: clearing the pointers and count discards the contents.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_count   = r_count;
  assign o_wr_err  = r_wr_err;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit buffer and launcher placed in front of uart_tx.
// Ports:
//   clk, reset             - rising-edge clock, synchronous active-high reset
//   i_wr, i_wr_data        - host byte write, accepted when not full
//   o_full, o_empty        - FIFO status (registered)
//   o_count                - FIFO occupancy, 0..DEPTH. The in-flight byte is excluded.
//   o_wr_err               - one-cycle pulse when a write was dropped
//   o_tx_start             - one-cycle start pulse to uart_tx.i_tx_signal
//   o_tx_data              - byte in flight, to uart_tx.i_data_byte
//   i_tx_done              - completion pulse from uart_tx.o_tx_done
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr,
  input  logic [7:0]        i_wr_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_wr_err,
  output logic              o_tx_start,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_done
);

  localparam int         BYTE_W  = 8;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              w_pop;
  logic              w_empty;
  logic [BYTE_W-1:0] w_head;
  logic              r_tx_start;
  logic [BYTE_W-1:0] r_tx_data;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .WIDTH  (BYTE_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr      (i_wr),
    .i_wr_data (i_wr_data),
    .i_rd      (w_pop),
    .o_rd_data (w_head),
    .o_full    (o_full),
    .o_empty   (w_empty),
    .o_count   (o_count),
    .o_wr_err  (o_wr_err)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state. i_tx_done only matters in WAIT, so a stale done is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_tx_done) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM decode: pop the head while idle with data buffered.
  always_comb begin
    w_pop = 1'b0;
    if ((r_state == S_IDLE) && !w_empty) begin
      w_pop = 1'b1;
    end else begin
      w_pop = 1'b0;
    end
  end

  // Output registers. The start pulse is registered from the START state, so it
  // follows the pop by one edge. The data byte is loaded only when it is popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_start <= (r_state == S_START);
      if (w_pop) begin
        r_tx_data <= w_head;
      end
    end
  end

  assign o_empty    = w_empty;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo (DEPTH=16).
module tb_uart_tx_fifo;

  logic       clk;
  logic       reset;
  logic       i_wr;
  logic [7:0] i_wr_data;
  logic       o_full;
  logic       o_empty;
  logic [4:0] o_count;
  logic       o_wr_err;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       i_tx_done;

  int n_pass;
  int n_total;
  int cyc;
  int start_cnt;
  int last_start_cyc;
  logic [7:0] sent_q [$];

  uart_tx_fifo #(.DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_wr       (i_wr),
    .i_wr_data  (i_wr_data),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_wr_err   (o_wr_err),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_done  (i_tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter plus start-pulse monitor, sampled 1 time unit after each edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (o_tx_start === 1'b1) begin
      sent_q.push_back(o_tx_data);
      start_cnt      = start_cnt + 1;
      last_start_cyc = cyc;
    end
  end

  // One write cycle. The caller is negedge-aligned and deasserts i_wr afterwards.
  task automatic drive_wr(input logic [7:0] d);
    i_wr      = 1'b1;
    i_wr_data = d;
    @(negedge clk);
  endtask

  // One-cycle done pulse. d returns the edge that samples it.
  task automatic pulse_done(output int d);
    i_tx_done = 1'b1;
    d         = cyc + 1;
    @(negedge clk);
    i_tx_done = 1'b0;
  endtask

  task automatic wait_starts(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (start_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_total++; if ({o_full, o_empty, o_wr_err, o_tx_start} !== 4'b0100) $display("FAIL reset_flags got full/empty/err/start=%b want 0100", {o_full, o_empty, o_wr_err, o_tx_start}); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++; if (o_count !== 5'd0 || o_empty !== 1'b1) $display("FAIL idle_status cycle %0d count=%0d empty=%b want 0/1", i, o_count, o_empty); else n_pass++;
    end
    n_total++; if (o_tx_data !== 8'h00) $display("FAIL idle_data got %h want 00", o_tx_data); else n_pass++;
    n_total++; if (start_cnt !== 0) $display("FAIL idle_no_start got %0d starts want 0", start_cnt); else n_pass++;
  endtask

  task automatic test_single();
    int base;
    int e0;
    int d;
    base = start_cnt;
    e0   = cyc + 1;
    drive_wr(8'hA5);
    i_wr = 1'b0;
    n_total++; if (o_count !== 5'd1 || o_empty !== 1'b0) $display("FAIL single_count_e0 count=%0d empty=%b want 1/0", o_count, o_empty); else n_pass++;
    @(negedge clk);
    n_total++; if (o_count !== 5'd0 || o_empty !== 1'b1) $display("FAIL single_count_e1 count=%0d empty=%b want 0/1", o_count, o_empty); else n_pass++;
    n_total++; if (o_tx_data !== 8'hA5 || o_tx_start !== 1'b0) $display("FAIL single_e1 data=%h start=%b want a5/0", o_tx_data, o_tx_start); else n_pass++;
    @(negedge clk);
    n_total++; if (o_tx_start !== 1'b1 || o_tx_data !== 8'hA5) $display("FAIL single_start start=%b data=%h want 1/a5", o_tx_start, o_tx_data); else n_pass++;
    n_total++; if (last_start_cyc !== e0 + 2) $display("FAIL single_latency start edge %0d want %0d", last_start_cyc, e0 + 2); else n_pass++;
    @(negedge clk);
    n_total++; if (o_tx_start !== 1'b0) $display("FAIL single_width start=%b want 0", o_tx_start); else n_pass++;
    pulse_done(d);
    repeat (10) @(negedge clk);
    n_total++; if (start_cnt !== base + 1) $display("FAIL single_no_more got %0d starts want %0d", start_cnt - base, 1); else n_pass++;
  endtask

  task automatic test_burst();
    int base;
    int d;
    bit ok;
    base = start_cnt;
    for (int i = 1; i <= 5; i++) drive_wr(8'(i));
    i_wr = 1'b0;
    wait_starts(base + 1, ok);
    n_total++; if (!ok) $display("FAIL burst_first_timeout got %0d starts want 1", start_cnt - base); else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      while (cyc < last_start_cyc + 19) @(negedge clk);
      pulse_done(d);
      if (k < 5) begin
        wait_starts(base + k + 1, ok);
        n_total++; if (!ok || last_start_cyc !== d + 2) $display("FAIL burst_gap byte %0d ok=%b start edge %0d want %0d", k + 1, ok, last_start_cyc, d + 2); else n_pass++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_total++; if (sent_q[base + i] !== 8'(i + 1)) $display("FAIL burst_order idx %0d got %h want %h", i, sent_q[base + i], 8'(i + 1)); else n_pass++;
    end
  endtask

  task automatic test_full();
    int base;
    int d;
    bit ok;
    base = start_cnt;
    for (int i = 0; i < 18; i++) begin
      drive_wr(8'h80 + 8'(i));
      if (i == 16) begin
        n_total++; if (o_full !== 1'b1 || o_count !== 5'd16 || o_wr_err !== 1'b0) $display("FAIL full_reached full=%b count=%0d err=%b want 1/16/0", o_full, o_count, o_wr_err); else n_pass++;
      end
      if (i == 17) begin
        n_total++; if (o_wr_err !== 1'b1 || o_count !== 5'd16) $display("FAIL overflow_err err=%b count=%0d want 1/16", o_wr_err, o_count); else n_pass++;
      end
    end
    i_wr = 1'b0;
    @(negedge clk);
    n_total++; if (o_wr_err !== 1'b0 || o_count !== 5'd16) $display("FAIL overflow_pulse err=%b count=%0d want 0/16", o_wr_err, o_count); else n_pass++;
    wait_starts(base + 1, ok);
    for (int i = 1; i <= 16; i++) begin
      pulse_done(d);
      wait_starts(base + 1 + i, ok);
    end
    n_total++; if (!ok) $display("FAIL full_drain_timeout got %0d starts want 17", start_cnt - base); else n_pass++;
    for (int i = 0; i < 17; i++) begin
      n_total++; if (sent_q[base + i] !== 8'h80 + 8'(i)) $display("FAIL full_order idx %0d got %h want %h", i, sent_q[base + i], 8'h80 + 8'(i)); else n_pass++;
    end
    pulse_done(d);
    repeat (10) @(negedge clk);
    n_total++; if (start_cnt !== base + 17 || o_empty !== 1'b1) $display("FAIL full_dropped starts=%0d empty=%b want 17/1", start_cnt - base, o_empty); else n_pass++;
  endtask

  task automatic test_simul();
    int base;
    int d;
    bit ok;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = start_cnt;
    for (int i = 0; i < 16; i++) drive_wr(8'h40 + 8'(i));
    i_wr = 1'b0;
    wait_starts(base + 1, ok);
    for (int i = 1; i <= 12; i++) begin
      pulse_done(d);
      wait_starts(base + 1 + i, ok);
    end
    n_total++; if (!ok || o_count !== 5'd3) $display("FAIL simul_setup ok=%b count=%0d want 1/3", ok, o_count); else n_pass++;
    pulse_done(d);
    i_wr      = 1'b1;
    i_wr_data = 8'h50;
    @(negedge clk);
    i_wr = 1'b0;
    n_total++; if (o_count !== 5'd3) $display("FAIL simul_count got %0d want 3", o_count); else n_pass++;
    wait_starts(base + 14, ok);
    n_total++; if (!ok || last_start_cyc !== d + 2) $display("FAIL simul_start ok=%b edge %0d want %0d", ok, last_start_cyc, d + 2); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      pulse_done(d);
      wait_starts(base + 15 + i, ok);
    end
    for (int i = 12; i < 17; i++) begin
      n_total++; if (sent_q[base + i] !== 8'h40 + 8'(i)) $display("FAIL simul_order idx %0d got %h want %h", i, sent_q[base + i], 8'h40 + 8'(i)); else n_pass++;
    end
    pulse_done(d);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int base;
    int d;
    int e0;
    bit ok;
    base = start_cnt;
    for (int i = 0; i < 4; i++) drive_wr(8'hC0 + 8'(i));
    i_wr = 1'b0;
    wait_starts(base + 1, ok);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_total++; if (o_empty !== 1'b1 || o_count !== 5'd0 || o_tx_data !== 8'h00) $display("FAIL midreset_state empty=%b count=%0d data=%h want 1/0/00", o_empty, o_count, o_tx_data); else n_pass++;
    base = start_cnt;
    pulse_done(d);
    repeat (10) @(negedge clk);
    n_total++; if (start_cnt !== base) $display("FAIL midreset_stale_done got %0d starts want 0", start_cnt - base); else n_pass++;
    e0 = cyc + 1;
    drive_wr(8'h3C);
    i_wr = 1'b0;
    wait_starts(base + 1, ok);
    n_total++; if (!ok || sent_q[sent_q.size() - 1] !== 8'h3C || last_start_cyc !== e0 + 2) $display("FAIL midreset_new ok=%b data=%h edge %0d want 3c at %0d", ok, sent_q[sent_q.size() - 1], last_start_cyc, e0 + 2); else n_pass++;
    pulse_done(d);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_pass         = 0;
    n_total        = 0;
    cyc            = 0;
    start_cnt      = 0;
    last_start_cyc = 0;
    reset          = 1'b1;
    i_wr           = 1'b0;
    i_wr_data      = 8'h00;
    i_tx_done      = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_simul();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
